// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer for a 15-bit LFSR byte scrambler: seeds the scrambler once per frame,
// streams frame_len bytes through it with a one-deep registered output, then pulses done.
module scrambler_frame_ctrl #(
  parameter int                DATA_W       = 8,
  parameter int                SEED_W       = 15,
  parameter int                LEN_W        = 12,
  parameter logic [SEED_W-1:0] DEFAULT_SEED = 15'h00A9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              seed_sel,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              scr_load,
  output logic [SEED_W-1:0] scr_seed,
  output logic              scr_en,
  output logic [DATA_W-1:0] scr_din,
  input  logic [DATA_W-1:0] scr_dout,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  remaining
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [SEED_W-1:0] scr_seed_q,  scr_seed_d;
  logic [DATA_W-1:0] m_data_q,    m_data_d;
  logic              m_valid_q,   m_valid_d;

  logic out_free;
  logic s_ready_c;
  logic beat;

  // The output register can take a new byte when it is empty or being drained this cycle.
  assign out_free  = !m_valid_q || m_ready;
  assign s_ready_c = (state_q == ST_RUN) && (remaining_q != '0) && out_free;
  assign beat      = s_valid && s_ready_c;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    remaining_d = remaining_q;
    scr_seed_d  = scr_seed_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = frame_len;
          scr_seed_d  = seed_sel ? seed_in : DEFAULT_SEED;
          state_d     = ST_LOAD;
        end
      end

      ST_LOAD: state_d = ST_RUN;

      ST_RUN: begin
        if (beat) begin
          m_data_d    = scr_dout;
          m_valid_d   = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
        end else if (m_ready) begin
          m_valid_d = 1'b0;
        end
        // A beat cannot occur once remaining is zero, so the held byte drains here.
        if ((remaining_q == '0) && out_free) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      scr_seed_q  <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      scr_seed_q  <= scr_seed_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign s_ready   = s_ready_c;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign scr_load  = (state_q == ST_LOAD);
  assign scr_seed  = scr_seed_q;
  assign scr_en    = beat;
  assign scr_din   = s_data;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign remaining = remaining_q;

  // Scrambler control must never load and step in the same cycle; a stalled byte must hold.
  a_load_en_exclusive: assert property (@(posedge clk) disable iff (rst) !(scr_load && scr_en));
  a_stall_holds: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule
